// File: rtl/timer_1hz_pkg.sv
// ============================================================================
// timer_1hz_pkg
// Shared widths, divider default and delay constants for the seconds timer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package timer_1hz_pkg;

  localparam int unsigned C_DIVIDE_DEF = 10;
  localparam int unsigned TIME_W       = 4;

  // Delays (in seconds) loaded by the anti-theft system FSM
  localparam logic [TIME_W-1:0] T_ARM       = 4'd6;
  localparam logic [TIME_W-1:0] T_DRIVER    = 4'd8;
  localparam logic [TIME_W-1:0] T_PASSENGER = 4'd15;
  localparam logic [TIME_W-1:0] T_ALARM     = 4'd10;

  function automatic logic [TIME_W-1:0] term_count(input int unsigned divide);
    return TIME_W'(divide - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider_1hz.sv
// ============================================================================
// divider_1hz
// Free-running phase counter producing a one-cycle enable every DIVIDE clocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module divider_1hz
  import timer_1hz_pkg::*;
#(
  parameter int unsigned DIVIDE = C_DIVIDE_DEF
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              clear,
  output logic [TIME_W-1:0] counter1Hz,
  output logic              clock1Hz
);

  localparam logic [TIME_W-1:0] C_TERM = term_count(DIVIDE);

  logic [TIME_W-1:0] phase_q;
  logic [TIME_W-1:0] phase_d;
  logic              term_w;

  assign term_w = (phase_q == C_TERM);

  always_comb begin
    phase_d = phase_q + 1'b1;
    if (clear || term_w) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign counter1Hz = phase_q;
  assign clock1Hz   = term_w;

endmodule

`default_nettype wire

// File: rtl/timer_1hz.sv
// ============================================================================
// timer_1hz
// Seconds countdown: loads a count on start, decrements per 1 Hz enable,
// pulses expired for one cycle when the count reaches zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_1hz
  import timer_1hz_pkg::*;
#(
  parameter int unsigned DIVIDE = C_DIVIDE_DEF
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              startTimer,
  input  logic [TIME_W-1:0] value,
  output logic              clock1Hz,
  output logic              expired,
  output logic              indicator,
  output logic [TIME_W-1:0] counter,
  output logic [TIME_W-1:0] counter1Hz
);

  logic [TIME_W-1:0] counter_q;
  logic [TIME_W-1:0] counter_d;
  logic              indicator_q;
  logic              indicator_d;
  logic              expired_q;
  logic              expired_d;
  logic              tick_w;

  divider_1hz #(
    .DIVIDE (DIVIDE)
  ) u_divider (
    .clock      (clock),
    .resetN     (resetN),
    .clear      (startTimer),
    .counter1Hz (counter1Hz),
    .clock1Hz   (tick_w)
  );

  // Start wins over tick; a zero-length start expires immediately
  always_comb begin
    counter_d   = counter_q;
    indicator_d = indicator_q;
    expired_d   = 1'b0;
    if (startTimer) begin
      counter_d   = value;
      indicator_d = (value != '0);
      expired_d   = (value == '0);
    end else if (tick_w && indicator_q) begin
      if (counter_q > TIME_W'(1)) begin
        counter_d = counter_q - 1'b1;
      end else begin
        counter_d   = '0;
        indicator_d = 1'b0;
        expired_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      counter_q   <= '0;
      indicator_q <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      indicator_q <= indicator_d;
      expired_q   <= expired_d;
    end
  end

  assign clock1Hz  = tick_w;
  assign expired   = expired_q;
  assign indicator = indicator_q;
  assign counter   = counter_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_1hz.sv
// ============================================================================
// tb_timer_1hz
// Scoreboard bench for timer_1hz at the default divide of 10.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer_1hz;

  localparam int DIV = 10;

  typedef struct {
    logic [3:0] div;
    logic       clk1;
    logic [3:0] cnt;
    logic       ind;
    logic       exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startTimer;
  logic [3:0] value;
  logic       clock1Hz;
  logic       expired;
  logic       indicator;
  logic [3:0] counter;
  logic [3:0] counter1Hz;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: predicted register contents after each edge
  logic [3:0] m_div = '0;
  logic [3:0] m_cnt = '0;
  logic       m_ind = 1'b0;
  logic       m_exp = 1'b0;

  int exp_pulses;

  always #5 clk = ~clk;

  timer_1hz #(.DIVIDE(DIV)) dut (
    .clock      (clk),
    .resetN     (resetN),
    .startTimer (startTimer),
    .value      (value),
    .clock1Hz   (clock1Hz),
    .expired    (expired),
    .indicator  (indicator),
    .counter    (counter),
    .counter1Hz (counter1Hz)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
    n_tests++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, req, $time);
    end
  endtask

  task automatic model_edge(input logic rn, input logic st, input logic [3:0] v);
    logic tick;
    exp_t e;
    tick = (m_div == 4'(DIV - 1));
    if (!rn) begin
      m_div = '0; m_cnt = '0; m_ind = 1'b0; m_exp = 1'b0;
    end else if (st) begin
      m_div = '0;
      m_cnt = v;
      m_ind = (v != 0);
      m_exp = (v == 0);
    end else begin
      m_exp = 1'b0;
      if (tick && m_ind) begin
        m_cnt = m_cnt - 4'd1;
        if (m_cnt == 0) begin
          m_ind = 1'b0;
          m_exp = 1'b1;
        end
      end
      m_div = tick ? 4'd0 : m_div + 4'd1;
    end
    e.div  = m_div;
    e.clk1 = (m_div == 4'(DIV - 1));
    e.cnt  = m_cnt;
    e.ind  = m_ind;
    e.exp  = m_exp;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then compare the DUT just after the edge
  task automatic step(input logic rn, input logic st, input logic [3:0] v);
    exp_t e;
    resetN     = rn;
    startTimer = st;
    value      = v;
    model_edge(rn, st, v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("counter1Hz", 8'(counter1Hz), 8'(e.div));
    check("clock1Hz",   8'(clock1Hz),   8'(e.clk1));
    check("counter",    8'(counter),    8'(e.cnt));
    check("indicator",  8'(indicator),  8'(e.ind));
    check("expired",    8'(expired),    8'(e.exp));
    if (expired === 1'b1) exp_pulses++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, value);
  endtask

  // Bounded wait for expiry; returns cycles from start edge to the pulse
  task automatic wait_expiry(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      step(1'b1, 1'b0, value);
      if (expired === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    resetN = 1'b0; startTimer = 1'b0; value = 4'd0;
    @(negedge clk);

    // Reset held two cycles, then free-running divider with timer idle
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd5);
    check("rst_counter1Hz", 8'(counter1Hz), 8'd0);
    check("rst_indicator",  8'(indicator),  8'd0);
    idle(25);

    // Zero value: immediate single-cycle expiry
    exp_pulses = 0;
    step(1'b1, 1'b1, 4'd0);
    check("zero_expired_now", 8'(expired), 8'd1);
    idle(12);
    check("zero_pulse_count", 8'(exp_pulses), 8'd1);

    // value=1: expiry 10 edges after the start edge
    step(1'b1, 1'b1, 4'd1);
    wait_expiry(30, cyc);
    check("v1_latency", 8'(cyc), 8'd10);
    idle(3);

    // value=3: three steps, one pulse, quiet afterwards
    exp_pulses = 0;
    step(1'b1, 1'b1, 4'd3);
    wait_expiry(60, cyc);
    check("v3_latency", 8'(cyc), 8'd30);
    idle(50);
    check("v3_pulse_count", 8'(exp_pulses), 8'd1);

    // Restart at E+15 with value=2; value changes while running are ignored
    exp_pulses = 0;
    step(1'b1, 1'b1, 4'd2);
    value = 4'd9;
    idle(14);
    step(1'b1, 1'b1, 4'd2);
    value = 4'd7;
    wait_expiry(40, cyc);
    check("restart_latency", 8'(cyc), 8'd20);
    check("restart_pulses",  8'(exp_pulses), 8'd1);
    idle(5);

    // Reset together with start mid-countdown clears everything
    exp_pulses = 0;
    step(1'b1, 1'b1, 4'd3);
    idle(15);
    step(1'b0, 1'b1, 4'd3);
    check("prio_rst_ind", 8'(indicator), 8'd0);
    idle(40);
    check("prio_rst_nopulse", 8'(exp_pulses), 8'd0);

    // Start held three cycles with value=1
    step(1'b1, 1'b1, 4'd1);
    step(1'b1, 1'b1, 4'd1);
    step(1'b1, 1'b1, 4'd1);
    wait_expiry(30, cyc);
    check("held_start_latency", 8'(cyc), 8'd10);
    idle(5);

    check("scoreboard_empty", 8'(sb_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_1hz.md
Name: timer_1hz

Overview:
- Seconds-countdown timer for the anti-theft FSM (arming delay, driver/passenger door delays, alarm-on period).
- A divider turns the system clock into a one-cycle 1 Hz enable (`clock1Hz`).
- `startTimer` loads a 4-bit second count into the timer. The timer decrements once per enable and pulses `expired` on reaching zero.
- `indicator` shows a countdown is in progress. Internal counts are exported for debug and status LEDs.

Parameters:
- DIVIDE, 10, system-clock cycles per "second"; legal range 2..16 (fits 4-bit `counter1Hz`). Silicon builds override it; simulation keeps the default.

Ports:
- clock  input  1  system clock; all state on rising edge.
- resetN  input  1  synchronous active-low reset.
- startTimer  input  1  level-sampled start/restart request.
- value  input  4  countdown length in seconds (0..15), sampled only on start.
- clock1Hz  output  1  one-cycle enable, high when the divider is at its terminal count.
- expired  output  1  registered one-cycle pulse when the countdown finishes.
- indicator  output  1  high while a countdown is running.
- counter  output  4  remaining seconds.
- counter1Hz  output  4  divider phase, 0..DIVIDE-1.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (resetN=0 at an edge): `counter1Hz`=0, `counter`=0, `indicator`=0, `expired`=0. Reset overrides start.
- Divider:
  - `counter1Hz` increments every cycle and wraps DIVIDE-1 -> 0.
  - It is forced to 0 on any edge where `startTimer`=1.
- `clock1Hz` = (`counter1Hz` == DIVIDE-1), combinational from the register. It toggles whether or not the timer is running.
- Start (`startTimer`=1 at an edge, `resetN`=1):
  - `counter` <= `value`, `counter1Hz` <= 0, `expired` <= 0.
  - `indicator` <= 1 if `value`!=0.
  - If `value`==0: `indicator` <= 0 and `expired` <= 1 (immediate expiry, no wait).
- Start holding high for several cycles reloads on each edge. Counting begins after the first edge with `startTimer`=0.
- Start during a running countdown is a restart (new `value`, divider cleared). Start has priority over tick and expiry in the same cycle.
- Tick (`clock1Hz`=1 and `indicator`=1 at an edge, no start):
  - `counter` > 1: `counter` <= `counter`-1.
  - `counter` == 1: `counter` <= 0, `indicator` <= 0, `expired` <= 1.
- `expired` is high for exactly one cycle, then cleared at the next edge.
- Idle (`indicator`=0): `counter` holds. `clock1Hz` still pulses, but ticks are ignored and there is no repeat expiry.
- Latency: start sampled at edge E with `value`=V>0 gives `expired` high during the cycle after edge E+V·DIVIDE. `counter` shows V-k after edge E+k·DIVIDE.
- A `value` change while running has no effect until the next start.
- No overflow: `counter` never decrements below 0.

Decomposition:
- Shared package: DIVIDE default, the 4-bit TIME_W width constant, and the named delay constants used by the system FSM (T_ARM, T_DRIVER, T_PASSENGER, T_ALARM).
- Sub-module `divider_1hz`:
  - Inputs: clock, resetN, clear.
  - Outputs: counter1Hz, clock1Hz.
  - Instantiated once; the countdown logic sits in timer_1hz.

Test Plan (DIVIDE=10):
- Reset: hold `resetN`=0 for 2 cycles -> all outputs 0, `counter1Hz`=0; release -> `counter1Hz` counts 0..9 and wraps; `clock1Hz` high only at 9; `indicator` stays 0.
- Zero value: `value`=0, pulse `startTimer` 1 cycle -> `expired` high for exactly 1 cycle after that edge; `indicator` stays 0; `counter`=0.
- value=1: start pulse at edge E -> `indicator`=1, `counter`=1 until edge E+10; then `counter`=0, `indicator`=0, `expired`=1 for one cycle.
- value=3: start pulse -> `counter` steps 3->2->1->0 at edges E+10, E+20, E+30; single `expired` pulse; no further pulses in the next 50 cycles.
- Restart: `value`=2, start; at E+15 pulse start again -> `counter` reloads to 2, `counter1Hz` cleared; expiry at E+15+20, and no expiry at E+20.
- Priority: assert `resetN`=0 simultaneously with `startTimer`=1 mid-countdown -> all state cleared, no `expired`; held start of 3 cycles with `value`=1 -> expiry 10 cycles after the last start edge.
